thread_scheduler: RTL and testbench



---
 rtl/thread_scheduler_if.sv | 42 ++++
 rtl/thread_scheduler.sv | 105 ++++++++++
 tb/tb_thread_scheduler.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/thread_scheduler_if.sv
// Fetch scheduler port bundle.
// master: upstream pipeline side (drives enables, stalls, park/wake, retire; observes grant).
// slave : the scheduler itself.
// Signals:
//   thread_en     per-thread enable mask
//   stalled       per-thread d-side stall from stage_tl
//   park_en/park_thread     IF reports an i-side miss for a thread
//   wake_en/wake_thread     i-side fill returned for a thread
//   retire_en/retire_thread WB consumed an instruction of a thread
//   sel_valid/sel_thread    registered fetch grant
//   parked        registered parked mask
//   inflight_err  sticky retire-at-zero error
interface thread_scheduler_if #(
    parameter int unsigned N_THREADS = 8
) ();
    localparam int unsigned TID_W = $clog2(N_THREADS);

    logic [N_THREADS-1:0] thread_en;
    logic [N_THREADS-1:0] stalled;
    logic                 park_en;
    logic [TID_W-1:0]     park_thread;
    logic                 wake_en;
    logic [TID_W-1:0]     wake_thread;
    logic                 retire_en;
    logic [TID_W-1:0]     retire_thread;
    logic                 sel_valid;
    logic [TID_W-1:0]     sel_thread;
    logic [N_THREADS-1:0] parked;
    logic                 inflight_err;

    modport master (
        output thread_en, stalled, park_en, park_thread, wake_en, wake_thread,
               retire_en, retire_thread,
        input  sel_valid, sel_thread, parked, inflight_err
    );

    modport slave (
        input  thread_en, stalled, park_en, park_thread, wake_en, wake_thread,
               retire_en, retire_thread,
        output sel_valid, sel_thread, parked, inflight_err
    );
endinterface

// File: rtl/thread_scheduler.sv
// Fetch-side round-robin thread scheduler for the barrel-threaded pipeline.
// Each cycle grants one eligible thread (enabled, not stalled, not parked, below its
// in-flight limit), searching from the thread after the last grant.
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-low reset
//   sched_io  thread_scheduler_if.slave bundle (inputs, registered grant, parked, error)
module thread_scheduler #(
    parameter int unsigned N_THREADS    = 8,
    parameter int unsigned MAX_INFLIGHT = 2
) (
    input logic                clk,
    input logic                rst,
    thread_scheduler_if.slave  sched_io
);
    localparam int unsigned TID_W = $clog2(N_THREADS);
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic                 sel_valid_q, sel_valid_d;
    logic [TID_W-1:0]     sel_thread_q, sel_thread_d;
    logic [TID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [N_THREADS-1:0] parked_q, parked_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     inflight_q [N_THREADS];
    logic [CNT_W-1:0]     inflight_d [N_THREADS];

    logic [CNT_W-1:0]     inflight_pre [N_THREADS];
    logic [N_THREADS-1:0] elig;
    logic                 found;
    logic [TID_W-1:0]     winner;
    logic [TID_W-1:0]     idx;

    // Park/wake, retire-adjusted counts and eligibility.
    always_comb begin
        err_d = err_q;
        for (int unsigned i = 0; i < N_THREADS; i++) begin
            // Wake wins over a same-cycle park of the same thread.
            parked_d[i] = (parked_q[i] |
                           (sched_io.park_en && sched_io.park_thread == TID_W'(i))) &
                          ~(sched_io.wake_en && sched_io.wake_thread == TID_W'(i));
            inflight_pre[i] = inflight_q[i];
            if (sched_io.retire_en && sched_io.retire_thread == TID_W'(i)) begin
                if (inflight_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    inflight_pre[i] = inflight_q[i] - CNT_W'(1);
                end
            end
            elig[i] = sched_io.thread_en[i] & ~sched_io.stalled[i] & ~parked_d[i] &
                      (inflight_pre[i] < CNT_W'(MAX_INFLIGHT));
        end
    end

    // Round-robin search starting after the last granted thread; k = N_THREADS wraps back
    // onto rr_ptr itself, so a lone eligible thread can be granted repeatedly.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr_q;
        idx    = '0;
        for (int unsigned k = 1; k <= N_THREADS; k++) begin
            idx = rr_ptr_q + TID_W'(k);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        sel_valid_d  = found;
        sel_thread_d = found ? winner : sel_thread_q;
        rr_ptr_d     = found ? winner : rr_ptr_q;
        for (int unsigned i = 0; i < N_THREADS; i++) begin
            // Granted threads are below the limit, so this cannot overflow.
            inflight_d[i] = inflight_pre[i] + CNT_W'(found && winner == TID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_valid_q  <= 1'b0;
            sel_thread_q <= '0;
            rr_ptr_q     <= TID_W'(N_THREADS - 1);
            parked_q     <= '0;
            err_q        <= 1'b0;
            for (int unsigned i = 0; i < N_THREADS; i++) begin
                inflight_q[i] <= '0;
            end
        end else begin
            sel_valid_q  <= sel_valid_d;
            sel_thread_q <= sel_thread_d;
            rr_ptr_q     <= rr_ptr_d;
            parked_q     <= parked_d;
            err_q        <= err_d;
            for (int unsigned i = 0; i < N_THREADS; i++) begin
                inflight_q[i] <= inflight_d[i];
            end
        end
    end

    assign sched_io.sel_valid    = sel_valid_q;
    assign sched_io.sel_thread   = sel_thread_q;
    assign sched_io.parked       = parked_q;
    assign sched_io.inflight_err = err_q;
endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler: directed scenarios plus randomized traffic,
// checked against a behavioural model of the scheduling rules.
module tb_thread_scheduler;
    localparam int N   = 8;
    localparam int MAX = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    thread_scheduler_if #(.N_THREADS(N)) bus ();

    thread_scheduler #(
        .N_THREADS   (N),
        .MAX_INFLIGHT(MAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sched_io(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    bit m_parked [N];
    int m_inf    [N];
    int m_rr;
    bit m_valid;
    int m_sel;
    bit m_err;

    typedef struct { int tid; int due; } pend_t;
    pend_t pend[$];
    int cyc = 0;
    bit auto_retire = 0;
    int ret_delay = 3;

    task automatic model_step();
        bit pn [N];
        int pre [N];
        bit el [N];
        int win;
        if (!rst) begin
            foreach (m_parked[i]) begin m_parked[i] = 0; m_inf[i] = 0; end
            m_rr = N - 1; m_valid = 0; m_sel = 0; m_err = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            pn[i] = (m_parked[i] || (bus.park_en && int'(bus.park_thread) == i)) &&
                    !(bus.wake_en && int'(bus.wake_thread) == i);
            pre[i] = m_inf[i];
            if (bus.retire_en && int'(bus.retire_thread) == i) begin
                if (m_inf[i] == 0) m_err = 1;
                else pre[i] = m_inf[i] - 1;
            end
            el[i] = bus.thread_en[i] && !bus.stalled[i] && !pn[i] && pre[i] < MAX;
        end
        win = -1;
        for (int k = 1; k <= N; k++) begin
            if (win < 0 && el[(m_rr + k) % N]) win = (m_rr + k) % N;
        end
        m_valid = (win >= 0);
        if (win >= 0) begin
            m_sel = win;
            m_rr  = win;
            pre[win]++;
        end
        for (int i = 0; i < N; i++) begin
            m_parked[i] = pn[i];
            m_inf[i]    = pre[i];
        end
    endtask

    task automatic step();
        bit retired = 0;
        logic [N-1:0] exp_parked;
        if (!rst) begin
            bus.retire_en = 1'b0;
        end else if (auto_retire) begin
            bus.retire_en = 1'b0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.retire_en     = 1'b1;
                bus.retire_thread = pend[0].tid[2:0];
                retired = 1;
            end
        end
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) exp_parked[i] = m_parked[i];
        check_eq("sel_valid", 32'(bus.sel_valid), 32'(m_valid));
        check_eq("sel_thread", 32'(bus.sel_thread), 32'(m_sel));
        check_eq("parked", 32'(bus.parked), 32'(exp_parked));
        check_eq("inflight_err", 32'(bus.inflight_err), 32'(m_err));
        if (!rst) begin
            pend.delete();
        end else begin
            if (retired) void'(pend.pop_front());
            if (m_valid) pend.push_back('{tid: m_sel, due: cyc + ret_delay});
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        bit seen;
        int exp_t;
        bus.thread_en = '1; bus.stalled = '0;
        bus.park_en = 0; bus.park_thread = '0;
        bus.wake_en = 0; bus.wake_thread = '0;
        bus.retire_en = 0; bus.retire_thread = '0;

        // Reset values, then full rotation with retires 3 cycles after each grant.
        auto_retire = 1; ret_delay = 3;
        do_reset();
        check_eq("rst_valid", 32'(bus.sel_valid), 0);
        check_eq("rst_thread", 32'(bus.sel_thread), 0);
        check_eq("rst_parked", 32'(bus.parked), 0);
        for (int k = 0; k < 10; k++) begin
            step();
            check_eq("rot_thread", 32'(bus.sel_thread), 32'(k % N));
            check_eq("rot_valid", 32'(bus.sel_valid), 1);
        end

        // Two enabled threads, no retires: hit the in-flight limit.
        auto_retire = 0;
        bus.thread_en = 8'b0000_0101;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("lim_thread", 32'(bus.sel_thread), 32'((k % 2) * 2));
        end
        step();
        check_eq("lim_idle", 32'(bus.sel_valid), 0);
        check_eq("lim_hold", 32'(bus.sel_thread), 2);
        bus.retire_en = 1; bus.retire_thread = 3'd2;
        step();
        bus.retire_en = 0;
        check_eq("lim_free_v", 32'(bus.sel_valid), 1);
        check_eq("lim_free_t", 32'(bus.sel_thread), 2);
        step();
        check_eq("lim_again", 32'(bus.sel_valid), 0);

        // Park thread 3 while the pointer sits on 2.
        bus.thread_en = '1;
        auto_retire = 1; ret_delay = 3;
        do_reset();
        repeat (3) step();
        bus.park_en = 1; bus.park_thread = 3'd3;
        step();
        bus.park_en = 0;
        check_eq("park_skip", 32'(bus.sel_thread), 4);
        check_eq("park_bit", 32'(bus.parked[3]), 1);
        for (int k = 0; k < 8; k++) begin
            step();
            check_eq("park_no3", 32'(bus.sel_thread == 3'd3), 0);
        end
        bus.wake_en = 1; bus.wake_thread = 3'd3;
        seen = 0;
        for (int k = 0; k < 9; k++) begin
            step();
            bus.wake_en = 0;
            if (bus.sel_valid && bus.sel_thread == 3'd3) seen = 1;
        end
        check_eq("wake_grant3", 32'(seen), 1);

        // Same-cycle park and wake of thread 5: wake wins.
        bus.park_en = 1; bus.park_thread = 3'd5;
        bus.wake_en = 1; bus.wake_thread = 3'd5;
        step();
        bus.park_en = 0; bus.wake_en = 0;
        check_eq("pw_parked5", 32'(bus.parked[5]), 0);
        seen = 0;
        for (int k = 0; k < 9; k++) begin
            step();
            if (bus.sel_valid && bus.sel_thread == 3'd5) seen = 1;
        end
        check_eq("pw_grant5", 32'(seen), 1);

        // Global stall for 4 cycles, then resume after the last grant.
        bus.stalled = '1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("stall_idle", 32'(bus.sel_valid), 0);
        end
        bus.stalled = '0;
        exp_t = (m_rr + 1) % N;
        step();
        check_eq("stall_resume", 32'(bus.sel_thread), 32'(exp_t));

        // Retire at count 0 sets the sticky error; only reset clears it.
        auto_retire = 0;
        bus.thread_en = '0;
        do_reset();
        bus.retire_en = 1; bus.retire_thread = 3'd6;
        step();
        bus.retire_en = 0;
        check_eq("err_set", 32'(bus.inflight_err), 1);
        bus.thread_en = '1;
        repeat (3) begin
            step();
            check_eq("err_sticky", 32'(bus.inflight_err), 1);
        end
        do_reset();
        check_eq("err_clear", 32'(bus.inflight_err), 0);

        // Randomized traffic.
        auto_retire = 1;
        for (int k = 0; k < 600; k++) begin
            bus.thread_en   = N'($urandom_range(0, 255) | $urandom_range(0, 255));
            bus.stalled     = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 255)) : '0;
            bus.park_en     = ($urandom_range(0, 5) == 0);
            bus.park_thread = 3'($urandom_range(0, N - 1));
            bus.wake_en     = ($urandom_range(0, 3) == 0);
            bus.wake_thread = 3'($urandom_range(0, N - 1));
            ret_delay       = $urandom_range(1, 6);
            if ($urandom_range(0, 79) == 0) do_reset();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
